// File: rtl/beat_buf_pkg.sv
// rtl/beat_buf_pkg.sv - shared defaults and FSM encoding for the beatmap bank reader
package beat_buf_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/beat_skid_fifo.sv
// rtl/beat_skid_fifo.sv - 2-entry byte FIFO with fall-through of the incoming word when empty
module beat_skid_fifo
    import beat_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              head;
    logic              store;
    logic              deq;
    logic              wr_idx;

    // An empty FIFO presents the arriving word directly; it is only stored if not taken.
    assign deq       = pop && (count != 2'd0);
    assign store     = push && !((count == 2'd0) && pop);
    assign wr_idx    = head ^ count[0];
    assign out_valid = (count != 2'd0) || push;
    assign out_data  = (count != 2'd0) ? mem[head] : (push ? push_data : '0);

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (deq) begin
                head <= ~head;
            end
            count <= count + {1'b0, store} - {1'b0, deq};
        end
    end

endmodule

// File: rtl/beat_bank_reader.sv
// rtl/beat_bank_reader.sv - drains full ping-pong beatmap banks in 0,1,0,1 order into a byte stream
module beat_bank_reader
    import beat_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_done,
    input  logic              fill_bank,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              release_pulse,
    output logic              release_bank,
    output logic              overflow
);

    state_t            state;
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic              ovf_hit;
    logic              cur_bank;
    logic              inflight;
    logic              inflight_bank;
    logic [1:0]        fifo_count;
    logic              go;
    logic              room;
    logic              issue;
    logic              last_issue;
    logic              pop;
    logic [DATA_W-1:0] push_data;

    // cur_bank flips on the final issue, so the release cycle already looks at the next bank.
    assign go         = (state == ST_STREAM) || full[cur_bank];
    assign room       = ({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2;
    assign issue      = go && room;
    assign last_issue = issue && (rd_addr == ADDR_W'(DEPTH - 1));

    assign rd_en     = issue;
    assign rd_bank   = cur_bank;
    assign push_data = inflight_bank ? rd_data1 : rd_data0;
    assign pop       = out_valid && out_ready;

    // A refill landing on the release cycle of the same bank is a legal new fill.
    always_comb begin
        full_next = full;
        ovf_hit   = 1'b0;
        if (release_pulse) begin
            full_next[release_bank] = 1'b0;
        end
        if (fill_done) begin
            if (full[fill_bank] && !(release_pulse && (release_bank == fill_bank))) begin
                ovf_hit = 1'b1;
            end else begin
                full_next[fill_bank] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            full          <= 2'b00;
            cur_bank      <= 1'b0;
            rd_addr       <= '0;
            inflight      <= 1'b0;
            inflight_bank <= 1'b0;
            release_pulse <= 1'b0;
            release_bank  <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            if (last_issue) begin
                state    <= ST_IDLE;
                rd_addr  <= '0;
                cur_bank <= ~cur_bank;
            end else if (issue) begin
                state   <= ST_STREAM;
                rd_addr <= rd_addr + 1'b1;
            end
            inflight <= issue;
            if (issue) begin
                inflight_bank <= cur_bank;
            end
            release_pulse <= last_issue;
            if (last_issue) begin
                release_bank <= cur_bank;
            end
            full <= full_next;
            if (ovf_hit) begin
                overflow <= 1'b1;
            end
        end
    end

    beat_skid_fifo #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .count     (fifo_count)
    );

endmodule

// File: doc/beat_bank_reader.md
# beat_bank_reader

Read-side controller for the beatmap ping-pong buffer pair: two 32×8 synchronous RAM banks, each filled by the beatmap writer. It tracks which bank the writer has marked full and drains that bank in address order into a valid/ready byte stream for the note renderer. It then returns the bank to the writer with a release pulse and moves to the other bank, so the writer and the display side never touch the same bank at the same time.

## Interface
- DATA_W, 8: byte width of beatmap entries
- ADDR_W, 5: bank address width
- DEPTH, 32: entries per bank; must be ≤ 2**ADDR_W
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- fill_done  in  1  one-cycle pulse: writer finished bank `fill_bank`
- fill_bank  in  1  bank index qualified by fill_done
- rd_en  out  1  read strobe to selected bank RAM
- rd_bank  out  1  bank being read
- rd_addr  out  ADDR_W  read address
- rd_data0  in  DATA_W  bank 0 RAM read data, valid 1 cycle after rd_en
- rd_data1  in  DATA_W  bank 1 RAM read data, valid 1 cycle after rd_en
- out_data  out  DATA_W  stream byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- release_pulse  out  1  one-cycle pulse: bank `release_bank` returned to writer
- release_bank  out  1  bank index qualified by release_pulse
- overflow  out  1  sticky: fill_done arrived for a bank already full

## Operation
- State: full[1:0] flags, cur_bank, rd_addr counter, FSM {IDLE, STREAM}, 2-entry output FIFO, in-flight flag for an issued-but-not-captured read.
- fill_done sets full[fill_bank]. If that bank is already full and is not being released in the same cycle, overflow is set sticky and the pulse is otherwise ignored.
- IDLE: if full[cur_bank], go to STREAM with rd_addr=0. Bank 1 is never read ahead of bank 0's turn; order is strictly 0,1,0,1…
- STREAM: issue rd_en with rd_bank=cur_bank when (FIFO occupancy + in-flight) < 2. Increment rd_addr on each issue.
- Read data (rd_data0 or rd_data1 per the bank latched at issue) is pushed into the FIFO the cycle after issue.
- The cycle after rd_en for address DEPTH-1:
  - release_pulse=1 and release_bank=cur_bank
  - full[cur_bank] cleared
  - cur_bank toggles
  - If full[new bank] is set, STREAM continues at rd_addr=0 in that same cycle (gapless). Otherwise go to IDLE.
- Same-cycle fill_done and release for the same bank: the flag ends set (new fill accepted) and overflow is not raised.
- out_valid = FIFO non-empty; out_data = FIFO head. A pop happens on the handshake. Push and pop in the same cycle are both honoured.
- Width rules: rd_addr wraps only via the explicit reset to 0 at bank switch and never counts past DEPTH-1. FIFO occupancy is 2 bits, 0–2.

## Timing
- Reset values: rd_en=0, rd_bank=0, rd_addr=0, out_valid=0, out_data=0, release_pulse=0, release_bank=0, overflow=0, cur_bank=0, full=00, FSM=IDLE, FIFO empty, in-flight cleared.
- Reset asserted mid-stream discards the in-flight read and FIFO contents. No release pulse is emitted.
- Latency: fill_done at cycle 0 (IDLE, bank 0) → rd_en addr 0 at cycle 1 → out_valid with byte 0 at cycle 2.
- Throughput: with out_ready held high, one byte per cycle. Byte k is presented at cycle 2+k.
- Backpressure: out_ready low holds out_data/out_valid stable. At most 2 bytes are buffered and issue stalls. No byte is lost or duplicated.
- release_pulse is exactly one cycle wide. It never asserts while rd_en targets the released bank.

## Structure
- Package beat_buf_pkg: DATA_W, ADDR_W, DEPTH defaults, FSM state enum {IDLE, STREAM}.
- Sub-module beat_skid_fifo: 2-entry, DATA_W-wide, sync-reset FIFO with push/pop/count. The top holds the FSM, flags and address counter.

## Test plan
- Reset, then fill_done bank 0 at cycle 0 with out_ready=1 → rd_en cycles 1–32 (addr 0–31), bytes 0–31 on cycles 2–33, release_pulse bank 0 at cycle 33.
- Both banks full, out_ready=1 → 64 consecutive bytes with no out_valid gap. Release bank 0 at cycle 33 and bank 1 at cycle 65.
- out_ready toggling 1,0,0,1 repeating on a full bank → all 32 bytes delivered in order, out_data stable while stalled, FIFO never exceeds 2.
- fill_done bank 0 twice before its release → overflow=1 sticky. Stream still delivers exactly 32 bytes once.
- fill_done bank 0 in the same cycle as release of bank 0 → full[0] remains set, overflow stays 0, bank 0 re-read after bank 1 turn.
- Reset asserted at byte 10 of a stream → all outputs return to reset values next cycle, no release pulse. A fresh fill_done restarts from bank 0 addr 0.
